repeated_subtractor: RTL and testbench

//   Unsigned sequential divider built on repeated subtraction. It is the inverse of
//   the repeated-addition multiplier used by the proportional path.

---
 rtl/repeated_subtractor.sv | 87 ++++++++
 tb/tb_repeated_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/repeated_subtractor.sv
// Unsigned sequential divider using repeated subtraction.
// Start/busy/done handshake, one subtract step per enabled clock.
module repeated_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] div_w;
    logic [WIDTH-1:0] q_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_w       <= '0;
            div_w       <= '0;
            q_w         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_w <= a;
                        div_w <= b;
                        q_w   <= '0;
                        busy  <= 1'b1;
                        // A zero divisor skips the loop and reports saturation.
                        if (b == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rem_w >= div_w) begin
                        rem_w <= rem_w - div_w;
                        q_w   <= q_w + 1'b1;
                    end else begin
                        state       <= DONE;
                        quotient    <= q_w;
                        remainder   <= rem_w;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repeated_subtractor.sv
// Scoreboard bench for repeated_subtractor: driver queues expected
// results, monitor checks them whenever done pulses.
module tb_repeated_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    typedef struct {
        logic [5:0] q;
        logic [5:0] r;
        logic       dbz;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;

    repeated_subtractor #(.WIDTH(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
        .a(a),
        .b(b),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] ia, input logic [5:0] ib,
                         input logic [5:0] eq, input logic [5:0] er,
                         input logic ed, input int el);
        exp_t e;
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dbz = ed;
        e.lat = el;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    // Monitor: pop one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                chk("done_pulse_prev_low", done_prev, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("latency", cyc - e.acc, e.lat);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, 7);
        wait_idle();
        issue(6'd20, 6'd0, 6'd63, 6'd20, 1'b1, 0);
        wait_idle();
        issue(6'd5, 6'd9, 6'd0, 6'd5, 1'b0, 1);
        wait_idle();
        issue(6'd9, 6'd9, 6'd1, 6'd0, 1'b0, 2);
        wait_idle();

        // Long run with a start pulse that must be ignored.
        issue(6'd63, 6'd1, 6'd63, 6'd0, 1'b0, 64);
        repeat (10) @(negedge clk);
        a     = 6'd2;
        b     = 6'd1;
        start = 1'b1;
        chk("busy_mid_run", busy, 1);
        chk("hold_quotient", quotient, 1);
        chk("hold_remainder", remainder, 0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored", busy, 1);
        wait_idle();
        repeat (3) @(negedge clk);

        // Clock enable dropped for three edges mid-run.
        issue(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, 10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        wait_idle();

        // Asynchronous reset mid-run, checked between edges.
        issue(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, 7);
        repeat (3) @(negedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_quotient", quotient, 0);
        chk("async_remainder", remainder, 0);
        chk("async_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'd10, 6'd3, 6'd3, 6'd1, 1'b0, 4);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
